// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI4 SRAM slave endpoint.
package axi_slv_pkg;

  localparam int unsigned AXI_IDS_BITS = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrData,
    StWrResp
  } state_e;

  // Active-low bit write enable from a byte strobe.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    bweb = '1;
    for (int k = 0; k < 4; k++) begin
      bweb[8*k +: 8] = {8{~strb[k]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Burst word-address counter: loads the start word, steps per beat, holds for FIXED bursts
// and wraps modulo 2**SRAM_AW for everything else.
module axi_burst_addr
  import axi_slv_pkg::*;
#(
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SRAM_AW-1:0] start_addr,
  input  logic [1:0]         burst,
  input  logic               step,
  output logic [SRAM_AW-1:0] addr
);

  logic [SRAM_AW-1:0] addr_q;
  logic               fixed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      fixed_q <= 1'b0;
    end else if (load) begin
      addr_q  <= start_addr;
      fixed_q <= (burst == BURST_FIXED);
    end else if (step && !fixed_q) begin
      addr_q <= addr_q + SRAM_AW'(1);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave that serialises read/write bursts onto a single-port SRAM macro (1-cycle read).
// Define SRAM_RANGE_CHK_EN to flag requests outside BASE_ADDR's window with SLVERR.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned SRAM_AW   = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_IDS_BITS-1:0] AWID,
  input  logic [31:0]             AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [31:0]             WDATA,
  input  logic [3:0]              WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [AXI_IDS_BITS-1:0] BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [AXI_IDS_BITS-1:0] ARID,
  input  logic [31:0]             ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [AXI_IDS_BITS-1:0] RID,
  output logic [31:0]             RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    SRAM_CEB,
  output logic                    SRAM_WEB,
  output logic [31:0]             SRAM_BWEB,
  output logic [SRAM_AW-1:0]      SRAM_A,
  output logic [31:0]             SRAM_DI,
  input  logic [31:0]             SRAM_DO
);

  state_e state_q, state_d;

  logic [AXI_IDS_BITS-1:0] id_q;
  logic [3:0]              len_q;
  logic [3:0]              beat_q;
  logic                    last_wr_q;
  logic                    fresh_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [SRAM_AW-1:0]      addr_cnt;

  logic aw_hs, ar_hs, w_hs, r_hs, b_hs, rlast, both_valid;

  logic [AXI_IDS_BITS-1:0] req_id;
  logic [31:0]             req_addr;
  logic [3:0]              req_len;
  logic [1:0]              req_burst;

  assign both_valid = AWVALID & ARVALID;
  assign aw_hs      = AWVALID & AWREADY;
  assign ar_hs      = ARVALID & ARREADY;
  assign w_hs       = WVALID & WREADY;
  assign r_hs       = RVALID & RREADY;
  assign b_hs       = BVALID & BREADY;
  assign rlast      = (beat_q == len_q);

  assign req_id    = aw_hs ? AWID    : ARID;
  assign req_addr  = aw_hs ? AWADDR  : ARADDR;
  assign req_len   = aw_hs ? AWLEN   : ARLEN;
  assign req_burst = aw_hs ? AWBURST : ARBURST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          state_d = StWrData;
        end else if (ar_hs) begin
          state_d = StRdReq;
        end
      end
      StRdReq:  state_d = StRdData;
      StRdData: if (r_hs) state_d = rlast ? StIdle : StRdReq;
      StWrData: if (w_hs && WLAST) state_d = StWrResp;
      StWrResp: if (b_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Everything is decoded from state and masked by rst, so a mid-burst reset deselects at once.
  always_comb begin
    AWREADY   = 1'b0;
    ARREADY   = 1'b0;
    WREADY    = 1'b0;
    RVALID    = 1'b0;
    BVALID    = 1'b0;
    SRAM_CEB  = 1'b1;
    SRAM_WEB  = 1'b1;
    SRAM_BWEB = '1;
    SRAM_A    = '0;
    SRAM_DI   = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          AWREADY = !(both_valid && last_wr_q);
          ARREADY = !(both_valid && !last_wr_q);
        end
        StRdReq: begin
          SRAM_CEB = err_q;
          SRAM_A   = addr_cnt;
        end
        StRdData: RVALID = 1'b1;
        StWrData: begin
          WREADY = 1'b1;
          if (WVALID) begin
            SRAM_CEB  = err_q;
            SRAM_WEB  = 1'b0;
            SRAM_A    = addr_cnt;
            SRAM_DI   = WDATA;
            SRAM_BWEB = strb_to_bweb(WSTRB);
          end
        end
        StWrResp: BVALID = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      last_wr_q <= 1'b0;
      fresh_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      fresh_q <= (state_q == StRdReq);
      if (fresh_q) begin
        rdata_q <= SRAM_DO;
      end
      if (aw_hs || ar_hs) begin
        id_q      <= req_id;
        len_q     <= req_len;
        beat_q    <= '0;
        last_wr_q <= aw_hs;
      end else if (w_hs || (r_hs && !rlast)) begin
        beat_q <= beat_q + 4'd1;
      end
    end
  end

`ifdef SRAM_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (aw_hs || ar_hs) begin
      err_q <= (req_addr[31:SRAM_AW+2] != BASE_ADDR[31:SRAM_AW+2]);
    end
  end
`else
  assign err_q = 1'b0;
`endif

  axi_burst_addr #(
    .SRAM_AW (SRAM_AW)
  ) u_burst_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs | ar_hs),
    .start_addr (req_addr[SRAM_AW+1:2]),
    .burst      (req_burst),
    .step       (w_hs | (r_hs & ~rlast)),
    .addr       (addr_cnt)
  );

  // SRAM_DO is live only in the first RD_DATA cycle; later cycles replay the held copy.
  assign RDATA = err_q ? 32'h0 : (fresh_q ? SRAM_DO : rdata_q);
  assign RID   = id_q;
  assign BID   = id_q;
  assign RLAST = RVALID & rlast;
  assign RRESP = err_q ? RESP_SLVERR : RESP_OKAY;
  assign BRESP = err_q ? RESP_SLVERR : RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{AWSIZE, ARSIZE, AWADDR, ARADDR, BASE_ADDR};

endmodule
